// File: rtl/mul_err_pkg.sv
// Shared widths and FSM state type for the multiplier error sweep controller.
package mul_err_pkg;

   localparam int unsigned OP_W   = 8;
   localparam int unsigned PROD_W = 16;
   localparam int unsigned ERR_W  = 17;
   localparam int unsigned CNT_W  = 17;
   localparam int unsigned SUM_W  = 33;
   localparam int unsigned SQ_W   = 48;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/mul_err_accum.sv
// Error register plus the four error statistics accumulators.
module mul_err_accum
   import mul_err_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   input  logic [PROD_W-1:0]        exact,
   input  logic [PROD_W-1:0]        approx,
   output logic [CNT_W-1:0]         err_cnt,
   output logic [PROD_W-1:0]        max_err,
   output logic signed [SUM_W-1:0]  sum_err,
   output logic [SQ_W-1:0]          sum_sq_err
);

   logic signed [ERR_W-1:0] err_q, err_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [PROD_W-1:0]       max_q, max_d;
   logic signed [SUM_W-1:0] sum_q, sum_d;
   logic [SQ_W-1:0]         sq_q, sq_d;
   logic [PROD_W-1:0]       abs_c;
   logic [2*PROD_W-1:0]     sq_c;

   // The accumulators consume the err value registered on the previous enabled edge.
   always_comb begin
      abs_c = err_q[ERR_W-1] ? PROD_W'(-err_q) : PROD_W'(err_q);
      sq_c  = (2*PROD_W)'(abs_c) * (2*PROD_W)'(abs_c);
      err_d = err_q;
      cnt_d = cnt_q;
      max_d = max_q;
      sum_d = sum_q;
      sq_d  = sq_q;
      if (clr) begin
         err_d = '0;
         cnt_d = '0;
         max_d = '0;
         sum_d = '0;
         sq_d  = '0;
      end else if (en) begin
         err_d = ERR_W'({1'b0, exact}) - ERR_W'({1'b0, approx});
         cnt_d = cnt_q + CNT_W'(err_q != '0);
         max_d = (abs_c > max_q) ? abs_c : max_q;
         sum_d = sum_q + SUM_W'(err_q);
         sq_d  = sq_q + SQ_W'(sq_c);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= '0;
         cnt_q <= '0;
         max_q <= '0;
         sum_q <= '0;
         sq_q  <= '0;
      end else begin
         err_q <= err_d;
         cnt_q <= cnt_d;
         max_q <= max_d;
         sum_q <= sum_d;
         sq_q  <= sq_d;
      end
   end

   assign err_cnt    = cnt_q;
   assign max_err    = max_q;
   assign sum_err    = sum_q;
   assign sum_sq_err = sq_q;

endmodule

// File: rtl/mul_err_sweep_ctrl.sv
// Sweeps all operand pairs through an external multiplier and gathers error statistics.
module mul_err_sweep_ctrl #(
   parameter int unsigned MUL_LAT = 0,
   parameter int unsigned OP_W    = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic                                 abort,
   output logic [OP_W-1:0]                      mul_a,
   output logic [OP_W-1:0]                      mul_b,
   input  logic [2*OP_W-1:0]                    mul_p,
   output logic                                 busy,
   output logic                                 done,
   output logic [mul_err_pkg::CNT_W-1:0]        err_cnt,
   output logic [mul_err_pkg::PROD_W-1:0]       max_err,
   output logic signed [mul_err_pkg::SUM_W-1:0] sum_err,
   output logic [mul_err_pkg::SQ_W-1:0]         sum_sq_err
);

   import mul_err_pkg::*;

   localparam int unsigned IDX_W  = 2 * OP_W;
   localparam int unsigned DEPTH  = MUL_LAT + 1;
   localparam int unsigned DCNT_W = $clog2(MUL_LAT + 2);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [OP_W-1:0]   a_q [DEPTH];
   logic [OP_W-1:0]   a_d [DEPTH];
   logic [OP_W-1:0]   b_q [DEPTH];
   logic [OP_W-1:0]   b_d [DEPTH];
   logic              v_q [DEPTH];
   logic              v_d [DEPTH];
   logic              accept_c;
   logic              en_c;
   logic [IDX_W-1:0]  exact_c;
   logic [IDX_W-1:0]  approx_c;

   // Stage 0 of the delay line is the registered operand output itself.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dcnt_d  = dcnt_q;
      done_d  = 1'b0;
      a_d[0]  = '0;
      b_d[0]  = '0;
      v_d[0]  = 1'b0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         a_d[i] = a_q[i-1];
         b_d[i] = b_q[i-1];
         v_d[i] = v_q[i-1];
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SWEEP;
               idx_d   = '0;
               v_d[0]  = 1'b1;
            end
         end
         SWEEP: begin
            if (abort) begin
               state_d = IDLE;
            end else if (idx_q == '1) begin
               state_d = DRAIN;
               dcnt_d  = '0;
            end else begin
               idx_d  = idx_q + IDX_W'(1);
               a_d[0] = idx_d[IDX_W-1:OP_W];
               b_d[0] = idx_d[OP_W-1:0];
               v_d[0] = 1'b1;
            end
         end
         DRAIN: begin
            if (!abort) begin
               done_d = (dcnt_q == DCNT_W'(MUL_LAT));
               if (dcnt_q == DCNT_W'(MUL_LAT + 1)) begin
                  state_d = IDLE;
               end else begin
                  dcnt_d = dcnt_q + DCNT_W'(1);
               end
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Aborting discards everything still in flight.
      if (state_q != IDLE && abort) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            a_d[i] = '0;
            b_d[i] = '0;
            v_d[i] = 1'b0;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         dcnt_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
            v_q[i] <= 1'b0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dcnt_q  <= dcnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            a_q[i] <= a_d[i];
            b_q[i] <= b_d[i];
            v_q[i] <= v_d[i];
         end
      end
   end

   // Idle pipeline slots feed zero into both sides so they add nothing.
   always_comb begin
      accept_c = (state_q == IDLE) && start;
      en_c     = (state_q != IDLE);
      exact_c  = '0;
      approx_c = '0;
      if (v_q[MUL_LAT]) begin
         exact_c  = IDX_W'(a_q[MUL_LAT]) * IDX_W'(b_q[MUL_LAT]);
         approx_c = mul_p;
      end
   end

   mul_err_accum u_accum (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (accept_c),
      .en         (en_c),
      .exact      (exact_c),
      .approx     (approx_c),
      .err_cnt    (err_cnt),
      .max_err    (max_err),
      .sum_err    (sum_err),
      .sum_sq_err (sum_sq_err)
   );

   assign mul_a = a_q[0];
   assign mul_b = b_q[0];
   assign busy  = busy_q;
   assign done  = done_q;

endmodule
